// File: rtl/itch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itch_pkg
// Description : Shared constants, types and helpers for the ITCH message
//               parser: message type codes, expected lengths, field byte
//               offsets, FSM state encoding and the parsed-message record.
// Revision    : 1.0 - initial release
// ============================================================================
package itch_pkg;

  // Order-affecting message type codes (ASCII)
  localparam logic [7:0] ITCH_ADD    = 8'h41;
  localparam logic [7:0] ITCH_DEL    = 8'h44;
  localparam logic [7:0] ITCH_EXEC   = 8'h45;
  localparam logic [7:0] ITCH_CANCEL = 8'h58;

  // Exact message lengths (type byte included)
  localparam int LEN_ADD    = 36;
  localparam int LEN_DEL    = 19;
  localparam int LEN_EXEC   = 31;
  localparam int LEN_CANCEL = 23;

  // Byte offsets within a message; offset 0 is the type byte
  localparam int OFF_LOCATE_FIRST = 1;
  localparam int OFF_LOCATE_LAST  = 2;
  localparam int OFF_REF_FIRST    = 11;
  localparam int OFF_REF_LAST     = 18;
  localparam int OFF_ADD_SIDE     = 19;
  localparam int OFF_ADD_SH_FIRST = 20;
  localparam int OFF_ADD_SH_LAST  = 23;
  localparam int OFF_ADD_PX_FIRST = 32;
  localparam int OFF_ADD_PX_LAST  = 35;
  localparam int OFF_EX_SH_FIRST  = 19;
  localparam int OFF_EX_SH_LAST   = 22;

  typedef enum logic [2:0] {
    ST_LEN_HI = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_TYPE   = 3'd2,
    ST_BODY   = 3'd3,
    ST_SKIP   = 3'd4
  } state_e;

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [15:0] locate;
    logic [63:0] order_ref;
    logic        side;
    logic [31:0] shares;
    logic [31:0] price;
  } itch_msg_t;

  // Expected length for a supported type; 0 marks an unsupported type
  function automatic int expected_len(input logic [7:0] t);
    case (t)
      ITCH_ADD:    return LEN_ADD;
      ITCH_DEL:    return LEN_DEL;
      ITCH_EXEC:   return LEN_EXEC;
      ITCH_CANCEL: return LEN_CANCEL;
      default:     return 0;
    endcase
  endfunction

  function automatic logic in_range(input int off, input int lo, input int hi);
    return (off >= lo) && (off <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/itch_msg_parser.sv
`default_nettype none
// ============================================================================
// Module      : itch_msg_parser
// Description : Frames length-prefixed ITCH messages from a valid-qualified
//               byte stream, decodes Add/Delete/Execute/Cancel and emits one
//               registered pulse per decoded message. Other types and bad
//               lengths are skipped by length. Optional statistics counters
//               are built when ITCH_PARSE_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module itch_msg_parser
  import itch_pkg::*;
#(
  parameter int MAX_MSG_LEN = 64,
  parameter int LEN_W       = 16
) (
  input  logic        clkIn,
  input  logic        rstBIn,
  input  logic        itchDataValidIn,
  input  logic [7:0]  itchDataIn,
  output logic        msgValidOut,
  output logic [7:0]  msgTypeOut,
  output logic [15:0] stockLocateOut,
  output logic [63:0] orderRefOut,
  output logic        sideOut,
  output logic [31:0] sharesOut,
  output logic [31:0] priceOut,
  output logic        errOut
`ifdef ITCH_PARSE_STATS_EN
  ,
  output logic [31:0] msgCntOut,
  output logic [31:0] skipCntOut,
  output logic [15:0] errCntOut
`endif
);

  state_e           state_q, state_d;
  logic [7:0]       hi_q, hi_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  itch_msg_t        fld_q, fld_d;
  itch_msg_t        out_q, out_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic             skip_pulse;
  logic [LEN_W-1:0] len_full;
  logic             last_byte;
  logic             type_ok;

  assign len_full  = LEN_W'({hi_q, itchDataIn});
  assign last_byte = (cnt_q == len_q - LEN_W'(1));
  assign type_ok   = (expected_len(itchDataIn) != 0);

  // Next-state, field capture and output pulse generation
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    fld_d      = fld_q;
    out_d      = out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    skip_pulse = 1'b0;
    if (itchDataValidIn) begin
      case (state_q)
        ST_LEN_HI: begin
          hi_d    = itchDataIn;
          state_d = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d = len_full;
          // Skip from here must cover all len bytes, so count from zero
          cnt_d = '0;
          if (len_full == '0) begin
            state_d = ST_LEN_HI;
          end else if (len_full > LEN_W'(MAX_MSG_LEN)) begin
            err_d   = 1'b1;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_TYPE;
          end
        end
        ST_TYPE: begin
          fld_d          = '0;
          fld_d.msg_type = itchDataIn;
          cnt_d          = LEN_W'(1);
          if (len_q == LEN_W'(1)) begin
            err_d      = type_ok;
            skip_pulse = !type_ok;
            state_d    = ST_LEN_HI;
          end else if (!type_ok) begin
            skip_pulse = 1'b1;
            state_d    = ST_SKIP;
          end else if (len_q != LEN_W'(expected_len(itchDataIn))) begin
            err_d   = 1'b1;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_BODY;
          end
        end
        ST_BODY: begin
          if (in_range(int'(cnt_q), OFF_LOCATE_FIRST, OFF_LOCATE_LAST))
            fld_d.locate = {fld_q.locate[7:0], itchDataIn};
          if (in_range(int'(cnt_q), OFF_REF_FIRST, OFF_REF_LAST))
            fld_d.order_ref = {fld_q.order_ref[55:0], itchDataIn};
          if (fld_q.msg_type == ITCH_ADD) begin
            if (int'(cnt_q) == OFF_ADD_SIDE)
              fld_d.side = (itchDataIn == 8'h42);
            if (in_range(int'(cnt_q), OFF_ADD_SH_FIRST, OFF_ADD_SH_LAST))
              fld_d.shares = {fld_q.shares[23:0], itchDataIn};
            if (in_range(int'(cnt_q), OFF_ADD_PX_FIRST, OFF_ADD_PX_LAST))
              fld_d.price = {fld_q.price[23:0], itchDataIn};
          end else if ((fld_q.msg_type == ITCH_EXEC) || (fld_q.msg_type == ITCH_CANCEL)) begin
            if (in_range(int'(cnt_q), OFF_EX_SH_FIRST, OFF_EX_SH_LAST))
              fld_d.shares = {fld_q.shares[23:0], itchDataIn};
          end
          cnt_d = cnt_q + LEN_W'(1);
          if (last_byte) begin
            // Outputs only change here, so partial fields never leak out
            out_d   = fld_d;
            valid_d = 1'b1;
            state_d = ST_LEN_HI;
          end
        end
        ST_SKIP: begin
          cnt_d = cnt_q + LEN_W'(1);
          if (last_byte) state_d = ST_LEN_HI;
        end
        default: state_d = ST_LEN_HI;
      endcase
    end
  end

  // State, field and output registers
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state_q <= ST_LEN_HI;
      hi_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fld_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fld_q   <= fld_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign msgValidOut    = valid_q;
  assign errOut         = err_q;
  assign msgTypeOut     = out_q.msg_type;
  assign stockLocateOut = out_q.locate;
  assign orderRefOut    = out_q.order_ref;
  assign sideOut        = out_q.side;
  assign sharesOut      = out_q.shares;
  assign priceOut       = out_q.price;

`ifdef ITCH_PARSE_STATS_EN
  logic [31:0] msg_cnt_q;
  logic [31:0] skip_cnt_q;
  logic [15:0] err_cnt_q;

  // Saturating event counters
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      msg_cnt_q  <= '0;
      skip_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (valid_d && (msg_cnt_q != '1))     msg_cnt_q  <= msg_cnt_q + 32'd1;
      if (skip_pulse && (skip_cnt_q != '1)) skip_cnt_q <= skip_cnt_q + 32'd1;
      if (err_d && (err_cnt_q != '1))       err_cnt_q  <= err_cnt_q + 16'd1;
    end
  end

  assign msgCntOut  = msg_cnt_q;
  assign skipCntOut = skip_cnt_q;
  assign errCntOut  = err_cnt_q;
`endif

endmodule
`default_nettype wire
